// File: rtl/decode_issue_queue.sv
// rtl/decode_issue_queue.sv - instruction queue with pre-decode and MUL/DIV/FPU issue hold
// Optional feature macro: RV32F_EN (FP class decode and FPU busy tracking).
module decode_issue_queue #(
   parameter int DEPTH = 2,
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             flush_i,
   input  logic             instr_valid_i,
   input  logic [31:0]      instr_i,
   input  logic [31:0]      pc_i,
   output logic             instr_ready_o,
   output logic             issue_valid_o,
   input  logic             issue_ready_i,
   output logic [31:0]      issue_instr_o,
   output logic [31:0]      issue_pc_o,
   output logic [3:0]       issue_class_o,
   output logic             issue_illegal_o,
   output logic             issue_ecall_o,
   output logic             issue_ebreak_o,
   output logic             issue_mret_o,
   input  logic             muldiv_done_i,
   input  logic             fpu_done_i,
   output logic             muldiv_busy_o,
   output logic             fpu_busy_o,
   output logic [CNT_W-1:0] count_o
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   localparam logic [3:0] C_ALU    = 4'd0;
   localparam logic [3:0] C_BRANCH = 4'd1;
   localparam logic [3:0] C_JUMP   = 4'd2;
   localparam logic [3:0] C_LOAD   = 4'd3;
   localparam logic [3:0] C_STORE  = 4'd4;
   localparam logic [3:0] C_UPPER  = 4'd5;
   localparam logic [3:0] C_SYSTEM = 4'd6;
   localparam logic [3:0] C_MULDIV = 4'd7;
   localparam logic [3:0] C_FPOP   = 4'd8;
   localparam logic [3:0] C_FLW    = 4'd9;
   localparam logic [3:0] C_FSW    = 4'd10;
   localparam logic [3:0] C_UNK    = 4'd15;

   localparam logic [31:0] ECALL  = 32'h0000_0073;
   localparam logic [31:0] EBREAK = 32'h0010_0073;
   localparam logic [31:0] MRET   = 32'h3020_0073;

   logic [31:0]      instr_mem   [DEPTH];
   logic [31:0]      pc_mem      [DEPTH];
   logic [3:0]       class_mem   [DEPTH];
   logic             illegal_mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [CNT_W-1:0] count;
   logic             muldiv_busy, fpu_busy;
   logic             push, pop, blocked;
   logic [3:0]       dec_class;
   logic             dec_illegal;
   logic [6:0]       opcode, f7;
   logic [2:0]       f3;

   assign opcode = instr_i[6:0];
   assign f3     = instr_i[14:12];
   assign f7     = instr_i[31:25];

   always_comb begin
      dec_class   = C_UNK;
      dec_illegal = 1'b0;
      case (opcode)
         7'b0010011: begin
            dec_class = C_ALU;
            if ((f3 == 3'd1 && f7 != 7'h00) ||
                (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20))
               dec_illegal = 1'b1;
         end
         7'b0110011: begin
            dec_class = (f7 == 7'h01) ? C_MULDIV : C_ALU;
            // funct7 0x20 only encodes SUB and SRA
            if (!(f7 == 7'h00 || f7 == 7'h01 ||
                  (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))))
               dec_illegal = 1'b1;
         end
         7'b1100011: begin
            dec_class   = C_BRANCH;
            dec_illegal = (f3[2:1] == 2'b01);
         end
         7'b1101111: dec_class = C_JUMP;
         7'b1100111: begin
            dec_class   = C_JUMP;
            dec_illegal = (f3 != 3'd0);
         end
         7'b0000011: begin
            dec_class   = C_LOAD;
            dec_illegal = (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
         end
         7'b0100011: begin
            dec_class   = C_STORE;
            dec_illegal = (f3 > 3'd2);
         end
         7'b0110111, 7'b0010111: dec_class = C_UPPER;
         7'b1110011: begin
            dec_class = C_SYSTEM;
            if (f3 == 3'b100 ||
                (f3 == 3'b000 && instr_i != ECALL && instr_i != EBREAK && instr_i != MRET))
               dec_illegal = 1'b1;
         end
`ifdef RV32F_EN
         7'b1010011: dec_class = C_FPOP;
         7'b0000111: dec_class = C_FLW;
         7'b0100111: dec_class = C_FSW;
`endif
         default: begin
            dec_class   = C_UNK;
            dec_illegal = 1'b1;
         end
      endcase
   end

   assign instr_ready_o = (count != FULL_CNT);
   assign push          = instr_valid_i && instr_ready_o;

   assign issue_instr_o   = instr_mem[rd_ptr];
   assign issue_pc_o      = pc_mem[rd_ptr];
   assign issue_class_o   = class_mem[rd_ptr];
   assign issue_illegal_o = illegal_mem[rd_ptr];
   assign issue_ecall_o   = (issue_instr_o == ECALL);
   assign issue_ebreak_o  = (issue_instr_o == EBREAK);
   assign issue_mret_o    = (issue_instr_o == MRET);

   // A done pulse releases the hold in the same cycle it arrives
   assign blocked = (issue_class_o == C_MULDIV && muldiv_busy && !muldiv_done_i) ||
                    (issue_class_o == C_FPOP   && fpu_busy    && !fpu_done_i);
   assign issue_valid_o = (count != '0) && !blocked;
   assign pop           = issue_valid_o && issue_ready_i;

   always_ff @(posedge clk_i) begin
      if (push && !flush_i) begin
         instr_mem[wr_ptr]   <= instr_i;
         pc_mem[wr_ptr]      <= pc_i;
         class_mem[wr_ptr]   <= dec_class;
         illegal_mem[wr_ptr] <= dec_illegal;
      end
   end

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // A handed-off op keeps its unit busy regardless of a concurrent flush
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i)
         muldiv_busy <= 1'b0;
      else if (pop && issue_class_o == C_MULDIV)
         muldiv_busy <= 1'b1;
      else if (muldiv_done_i)
         muldiv_busy <= 1'b0;
   end

`ifdef RV32F_EN
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i)
         fpu_busy <= 1'b0;
      else if (pop && issue_class_o == C_FPOP)
         fpu_busy <= 1'b1;
      else if (fpu_done_i)
         fpu_busy <= 1'b0;
   end
`else
   logic unused_fpu_done;
   assign unused_fpu_done = fpu_done_i;
   assign fpu_busy        = 1'b0;
`endif

   assign muldiv_busy_o = muldiv_busy;
   assign fpu_busy_o    = fpu_busy;
   assign count_o       = count;
endmodule

// File: tb/tb_decode_issue_queue.sv
// tb/tb_decode_issue_queue.sv - scoreboard bench for decode_issue_queue
module tb_decode_issue_queue;
   localparam int DEPTH = 2;
   localparam int CNT_W = 2;
   localparam int NV    = 22;

   logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, instr_valid = 1'b0, issue_ready = 1'b0;
   logic muldiv_done = 1'b0, fpu_done = 1'b0;
   logic [31:0] instr = '0, pc = '0, pc_next = 32'h1000;
   logic instr_ready, issue_valid, issue_illegal, issue_ecall, issue_ebreak, issue_mret;
   logic muldiv_busy, fpu_busy;
   logic [31:0] issue_instr, issue_pc;
   logic [3:0] issue_class;
   logic [CNT_W-1:0] count;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [3:0]  cls;
      logic        ill;
      logic        ec;
      logic        eb;
      logic        mr;
   } exp_t;
   exp_t sb[$];
   int checks = 0, failures = 0;

   logic [31:0] v_instr [NV] = '{32'h00500093, 32'h00000073, 32'h00100073, 32'h30200073,
                                 32'h00001067, 32'hFFFFFFFF, 32'h00002083, 32'h00003083,
                                 32'h00112023, 32'h00113023, 32'h00000063, 32'h00002063,
                                 32'h000010B7, 32'h00000097, 32'h40000033, 32'h40001033,
                                 32'h40001013, 32'h40005013, 32'h00004073, 32'h30001073,
                                 32'h0000006F, 32'h10500073};
   logic [3:0]  v_cls [NV]   = '{4'd0, 4'd6, 4'd6, 4'd6, 4'd2, 4'd15, 4'd3, 4'd3,
                                 4'd4, 4'd4, 4'd1, 4'd1, 4'd5, 4'd5, 4'd0, 4'd0,
                                 4'd0, 4'd0, 4'd6, 4'd6, 4'd2, 4'd6};
   logic        v_ill [NV]   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1,
                                 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1,
                                 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

   decode_issue_queue #(.DEPTH(DEPTH)) dut (
      .clk_i(clk), .reset_i(rst_n), .flush_i(flush),
      .instr_valid_i(instr_valid), .instr_i(instr), .pc_i(pc), .instr_ready_o(instr_ready),
      .issue_valid_o(issue_valid), .issue_ready_i(issue_ready),
      .issue_instr_o(issue_instr), .issue_pc_o(issue_pc), .issue_class_o(issue_class),
      .issue_illegal_o(issue_illegal), .issue_ecall_o(issue_ecall),
      .issue_ebreak_o(issue_ebreak), .issue_mret_o(issue_mret),
      .muldiv_done_i(muldiv_done), .fpu_done_i(fpu_done),
      .muldiv_busy_o(muldiv_busy), .fpu_busy_o(fpu_busy), .count_o(count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] i, input logic [3:0] c, input logic il,
                       input logic ec, input logic eb, input logic mr);
      exp_t e;
      int n = 0;
      while (!instr_ready && n < 50) begin
         tick();
         n++;
      end
      chk("push_ready", 32'(instr_ready), 32'd1);
      e.instr = i; e.pc = pc_next; e.cls = c; e.ill = il; e.ec = ec; e.eb = eb; e.mr = mr;
      sb.push_back(e);
      instr = i;
      pc = pc_next;
      instr_valid = 1'b1;
      pc_next = pc_next + 32'd4;
      tick();
      instr_valid = 1'b0;
   endtask

   task automatic drain(input string name);
      int n = 0;
      while (sb.size() != 0 && n < 50) begin
         tick();
         n++;
      end
      chk(name, 32'(sb.size()), 32'd0);
      chk({name, "_count"}, 32'(count), 32'd0);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rst_n && issue_valid && issue_ready) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_issue actual=%h required=none", issue_instr);
         end else begin
            e = sb.pop_front();
            chk("issue_instr", issue_instr, e.instr);
            chk("issue_pc", issue_pc, e.pc);
            chk("issue_class", 32'(issue_class), 32'(e.cls));
            chk("issue_illegal", 32'(issue_illegal), 32'(e.ill));
            chk("issue_ecall", 32'(issue_ecall), 32'(e.ec));
            chk("issue_ebreak", 32'(issue_ebreak), 32'(e.eb));
            chk("issue_mret", 32'(issue_mret), 32'(e.mr));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_ready", 32'(instr_ready), 32'd1);
      chk("rst_valid", 32'(issue_valid), 32'd0);
      chk("rst_mbusy", 32'(muldiv_busy), 32'd0);
      chk("rst_fbusy", 32'(fpu_busy), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // fill, overflow attempt, then drain in order
      push(32'h00500093, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      push(32'h00A00113, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("full_count", 32'(count), 32'd2);
      chk("full_ready", 32'(instr_ready), 32'd0);
      instr = 32'h00300193;
      instr_valid = 1'b1;
      tick();
      instr_valid = 1'b0;
      chk("overflow_count", 32'(count), 32'd2);
      issue_ready = 1'b1;
      drain("drain1");

      // MUL issues, DIV held until done pulse
      issue_ready = 1'b0;
      push(32'h022081B3, 4'd7, 1'b0, 1'b0, 1'b0, 1'b0);
      push(32'h0220C233, 4'd7, 1'b0, 1'b0, 1'b0, 1'b0);
      issue_ready = 1'b1;
      tick();
      chk("mul_busy", 32'(muldiv_busy), 32'd1);
      chk("div_held", 32'(issue_valid), 32'd0);
      repeat (3) tick();
      chk("div_held_late", 32'(issue_valid), 32'd0);
      chk("div_held_count", 32'(count), 32'd1);
      muldiv_done = 1'b1;
      #1;
      chk("div_valid_on_done", 32'(issue_valid), 32'd1);
      @(posedge clk);
      #1;
      muldiv_done = 1'b0;
      chk("busy_set_and_done", 32'(muldiv_busy), 32'd1);
      chk("div_popped", 32'(count), 32'd0);
      chk("div_sb", 32'(sb.size()), 32'd0);

      // ALU not held by busy unit
      push(32'h00700393, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      drain("alu_not_held");

      // flush with full queue and a concurrent push
      issue_ready = 1'b0;
      push(32'h00100093, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      push(32'h00200093, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      flush = 1'b1;
      instr = 32'h00900493;
      instr_valid = 1'b1;
      tick();
      flush = 1'b0;
      instr_valid = 1'b0;
      sb.delete();
      chk("flush_count", 32'(count), 32'd0);
      chk("flush_valid", 32'(issue_valid), 32'd0);
      chk("flush_busy_kept", 32'(muldiv_busy), 32'd1);
      tick();
      chk("flush_dropped", 32'(count), 32'd0);
      muldiv_done = 1'b1;
      tick();
      muldiv_done = 1'b0;
      chk("done_clears", 32'(muldiv_busy), 32'd0);
      muldiv_done = 1'b1;
      tick();
      muldiv_done = 1'b0;
      chk("done_idle", 32'(muldiv_busy), 32'd0);

      // decode table
      issue_ready = 1'b1;
      for (int k = 0; k < NV; k++)
         push(v_instr[k], v_cls[k], v_ill[k], v_instr[k] == 32'h00000073,
              v_instr[k] == 32'h00100073, v_instr[k] == 32'h30200073);
      drain("decode");

      // FP op, build dependent
`ifdef RV32F_EN
      push(32'h001071D3, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0);
      drain("fadd");
      chk("fpu_busy", 32'(fpu_busy), 32'd1);
      fpu_done = 1'b1;
      tick();
      fpu_done = 1'b0;
      chk("fpu_clear", 32'(fpu_busy), 32'd0);
`else
      push(32'h001071D3, 4'd15, 1'b1, 1'b0, 1'b0, 1'b0);
      drain("fadd");
      chk("fpu_busy", 32'(fpu_busy), 32'd0);
`endif

      // streaming with reset mid-stream; busy set first to see reset clear it
      push(32'h022081B3, 4'd7, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 3 * DEPTH + 1; k++) begin
         if (k == 4) begin
            rst_n = 1'b0;
            #1;
            chk("mid_rst_valid", 32'(issue_valid), 32'd0);
            chk("mid_rst_count", 32'(count), 32'd0);
            chk("mid_rst_ready", 32'(instr_ready), 32'd1);
            chk("mid_rst_busy", 32'(muldiv_busy), 32'd0);
            sb.delete();
            @(negedge clk);
            rst_n = 1'b1;
            tick();
         end
         push(32'h00000013 | (32'(k) << 20), 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      drain("stream");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
